// File: rtl/riscv_dmem_responder_pkg.sv
// Shared parameters for the data-memory responder.
// FSM state codes, access-size encodings and wait limit.
package riscv_dmem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] MEMOP_WORD = 2'b00;
  localparam logic [1:0] MEMOP_BYTE = 2'b01;
  localparam logic [1:0] MEMOP_HALF = 2'b10;
  localparam logic [1:0] MEMOP_INV  = 2'b11;

  localparam int DMEM_WAIT_MAX = 15;

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// Execute-stage to data-memory request/response bundle.
// master drives requests, slave returns data and acks.
interface riscv_dmem_responder_if;

  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic [1:0]  dmem_data_size;
  logic        dmem_read_req;
  logic        dmem_write_req;
  logic [31:0] dmem_data_out;
  logic        dmem_read_ack;
  logic        dmem_write_ack;
  logic        dmem_busy;
  logic        dmem_error;

  modport master (
    output dmem_address,
    output dmem_data_in,
    output dmem_data_size,
    output dmem_read_req,
    output dmem_write_req,
    input  dmem_data_out,
    input  dmem_read_ack,
    input  dmem_write_ack,
    input  dmem_busy,
    input  dmem_error
  );

  modport slave (
    input  dmem_address,
    input  dmem_data_in,
    input  dmem_data_size,
    input  dmem_read_req,
    input  dmem_write_req,
    output dmem_data_out,
    output dmem_read_ack,
    output dmem_write_ack,
    output dmem_busy,
    output dmem_error
  );

endinterface

// File: rtl/riscv_dmem_lane_ctrl.sv
// Byte-lane steering for sub-word loads and stores.
// Pure combinational; alignment checked against access size.
module riscv_dmem_lane_ctrl
  import riscv_dmem_responder_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [31:0] rshift;
  logic [15:0] rhalf;

  assign rshift = rword >> {lane, 3'b000};
  assign rhalf  = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en     = '0;
    wdata_lanes = '0;
    rdata       = '0;
    misaligned  = 1'b0;
    unique case (1'b1)
      size == MEMOP_BYTE: begin
        byte_en     = 4'b0001 << lane;
        wdata_lanes = {4{wdata_in[7:0]}};
        rdata       = {24'd0, rshift[7:0]};
      end
      size == MEMOP_HALF: begin
        byte_en     = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_in[15:0]}};
        rdata       = {16'd0, rhalf};
        misaligned  = lane[0];
      end
      size == MEMOP_WORD: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata_in;
        rdata       = rword;
        misaligned  = lane != 2'b00;
      end
      size == MEMOP_INV: begin
        byte_en = '0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: IDLE/WAIT/RESP access FSM
// over a four-bank byte-wide storage array.
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic                   clk,
  input logic                   reset_n,
  riscv_dmem_responder_if.slave dmem
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(DMEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
  localparam logic [1:0] ST_ACCEPT =
    (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_data;
  logic [1:0]    lat_size;
  logic          lat_rd;
  logic          lat_wr;

  logic [31:0] data_out;
  logic        read_ack;
  logic        write_ack;
  logic        error;

  logic          req;
  logic          oob;
  logic          req_err;
  logic          mem_we;
  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lanes;
  logic [31:0]   rdata;
  logic          misaligned;

  assign req = dmem.dmem_read_req | dmem.dmem_write_req;
  assign idx = lat_addr[AW+1:2];
  assign oob = (lat_addr >> (AW + 2)) != 32'd0;

  assign req_err = (lat_size == MEMOP_INV) | misaligned
                 | oob | (lat_rd & lat_wr);

  assign mem_we = (state == ST_RESP) & lat_wr
                & ~lat_rd & ~req_err;

  riscv_dmem_lane_ctrl u_lane (
    .lane        (lat_addr[1:0]),
    .size        (lat_size),
    .wdata_in    (lat_data),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata       (rdata),
    .misaligned  (misaligned)
  );

  // One byte-wide bank per lane so each maps to a plain SRAM.
  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [7:0] bank [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (mem_we && byte_en[b]) begin
        bank[idx] <= wdata_lanes[8*b +: 8];
      end
    end

    assign rword[8*b +: 8] = bank[idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_size  <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      data_out  <= '0;
      read_ack  <= 1'b0;
      write_ack <= 1'b0;
      error     <= 1'b0;
    end else begin
      read_ack  <= 1'b0;
      write_ack <= 1'b0;
      error     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_addr <= dmem.dmem_address;
            lat_data <= dmem.dmem_data_in;
            lat_size <= dmem.dmem_data_size;
            lat_rd   <= dmem.dmem_read_req;
            lat_wr   <= dmem.dmem_write_req;
            cnt      <= CNT_INIT;
            state    <= ST_ACCEPT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          error <= req_err;
          if (lat_rd) begin
            read_ack <= 1'b1;
            data_out <= req_err ? 32'd0 : rdata;
          end else begin
            write_ack <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dmem.dmem_data_out  = data_out;
  assign dmem.dmem_read_ack  = read_ack;
  assign dmem.dmem_write_ack = write_ack;
  assign dmem.dmem_error     = error;
  assign dmem.dmem_busy      = ((state == ST_IDLE) & req)
                             | (state == ST_WAIT);

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder with
// one WAIT_CYCLES=1 and one WAIT_CYCLES=0 instance.
module tb_riscv_dmem_responder;
  import riscv_dmem_responder_pkg::*;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  logic [31:0] rd;
  logic        ra;
  logic        wa;
  logic        er;
  int          lat;
  int          bsy;

  riscv_dmem_responder_if bus1 ();
  riscv_dmem_responder_if bus0 ();

  riscv_dmem_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (1)
  ) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .dmem    (bus1)
  );

  riscv_dmem_responder #(
    .DEPTH_WORDS (64),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .dmem    (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic access(
    input  logic        r,
    input  logic        w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    output logic [31:0] rdata,
    output logic        rack,
    output logic        wack,
    output logic        err,
    output int          latency,
    output int          busy_n
  );
    latency = 0;
    busy_n  = 0;
    rdata   = '0;
    rack    = 1'b0;
    wack    = 1'b0;
    err     = 1'b0;
    @(negedge clk);
    bus1.dmem_address   = addr;
    bus1.dmem_data_in   = wdata;
    bus1.dmem_data_size = size;
    bus1.dmem_read_req  = r;
    bus1.dmem_write_req = w;
    #1;
    if (bus1.dmem_busy) busy_n++;
    @(posedge clk);
    #1;
    if (bus1.dmem_busy) busy_n++;
    bus1.dmem_read_req  = 1'b0;
    bus1.dmem_write_req = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus1.dmem_read_ack || bus1.dmem_write_ack) begin
        latency = k;
        rack    = bus1.dmem_read_ack;
        wack    = bus1.dmem_write_ack;
        err     = bus1.dmem_error;
        rdata   = bus1.dmem_data_out;
        break;
      end
      if (bus1.dmem_busy) busy_n++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    tests++;
    if (bus1.dmem_data_out !== 32'd0) begin
      fails++;
      $display("FAIL rst_data got %h exp 0", bus1.dmem_data_out);
    end
    tests++;
    if ({bus1.dmem_read_ack, bus1.dmem_write_ack} !== 2'b00) begin
      fails++;
      $display("FAIL rst_acks got %b exp 00",
        {bus1.dmem_read_ack, bus1.dmem_write_ack});
    end
    tests++;
    if ({bus1.dmem_busy, bus1.dmem_error} !== 2'b00) begin
      fails++;
      $display("FAIL rst_busy_err got %b exp 00",
        {bus1.dmem_busy, bus1.dmem_error});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_word;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL wr_latency got %0d exp 2", lat);
    end
    tests++;
    if ({ra, wa, er} !== 3'b010) begin
      fails++;
      $display("FAIL wr_acks got %b exp 010", {ra, wa, er});
    end
    tests++;
    if (bsy !== 2) begin
      fails++;
      $display("FAIL wr_busy got %0d exp 2", bsy);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus1.dmem_write_ack !== 1'b0) begin
      fails++;
      $display("FAIL wr_pulse got %b exp 0", bus1.dmem_write_ack);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if (rd !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rd_word got %h exp deadbeef", rd);
    end
    tests++;
    if ({lat, bsy} !== {32'd2, 32'd2}) begin
      fails++;
      $display("FAIL rd_timing got lat %0d busy %0d exp 2 2", lat, bsy);
    end
    tests++;
    if ({ra, wa, er} !== 3'b100) begin
      fails++;
      $display("FAIL rd_acks got %b exp 100", {ra, wa, er});
    end
  endtask

  task automatic test_byte;
    access(1'b0, 1'b1, 32'h10, 32'h11223344, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if (bus1.dmem_data_out !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL hold_data got %h exp deadbeef", bus1.dmem_data_out);
    end
    access(1'b0, 1'b1, 32'h13, 32'h123456AA, MEMOP_BYTE,
      rd, ra, wa, er, lat, bsy);
    access(1'b1, 1'b0, 32'h10, 32'h0, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if (rd !== 32'hAA223344) begin
      fails++;
      $display("FAIL byte_merge got %h exp aa223344", rd);
    end
    access(1'b1, 1'b0, 32'h13, 32'h0, MEMOP_BYTE,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if (rd !== 32'h000000AA) begin
      fails++;
      $display("FAIL byte_ld13 got %h exp 000000aa", rd);
    end
    access(1'b1, 1'b0, 32'h11, 32'h0, MEMOP_BYTE,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if (rd !== 32'h00000033) begin
      fails++;
      $display("FAIL byte_ld11 got %h exp 00000033", rd);
    end
    access(1'b1, 1'b0, 32'h12, 32'h0, MEMOP_HALF,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if (rd !== 32'h0000AA22) begin
      fails++;
      $display("FAIL half_ld12 got %h exp 0000aa22", rd);
    end
    access(1'b0, 1'b1, 32'h12, 32'hFFFF5566, MEMOP_HALF,
      rd, ra, wa, er, lat, bsy);
    access(1'b1, 1'b0, 32'h10, 32'h0, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if (rd !== 32'h55663344) begin
      fails++;
      $display("FAIL half_merge got %h exp 55663344", rd);
    end
  endtask

  task automatic test_errors;
    access(1'b1, 1'b0, 32'h11, 32'h0, MEMOP_HALF,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if ({ra, wa, er, rd} !== {3'b101, 32'd0}) begin
      fails++;
      $display("FAIL half_mis got acks %b data %h exp 101 0",
        {ra, wa, er}, rd);
    end
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL err_latency got %0d exp 2", lat);
    end
    access(1'b0, 1'b1, 32'h11, 32'hFFFFFFFF, MEMOP_HALF,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if ({ra, wa, er} !== 3'b011) begin
      fails++;
      $display("FAIL wr_mis got %b exp 011", {ra, wa, er});
    end
    access(1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    access(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, MEMOP_INV,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if ({ra, wa, er} !== 3'b011) begin
      fails++;
      $display("FAIL size_inv got %b exp 011", {ra, wa, er});
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if ({er, rd} !== {1'b0, 32'h55663344}) begin
      fails++;
      $display("FAIL err_nowrite got err %b data %h exp 0 55663344",
        er, rd);
    end
    access(1'b1, 1'b0, 32'h1000, 32'h0, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if ({ra, er, rd} !== {2'b11, 32'd0}) begin
      fails++;
      $display("FAIL oob got ack %b err %b data %h exp 1 1 0",
        ra, er, rd);
    end
    access(1'b0, 1'b1, 32'hFFC, 32'h0F0F0F0F, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    access(1'b1, 1'b0, 32'hFFC, 32'h0, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if ({er, rd} !== {1'b0, 32'h0F0F0F0F}) begin
      fails++;
      $display("FAIL top_word got err %b data %h exp 0 0f0f0f0f",
        er, rd);
    end
  endtask

  task automatic test_both;
    access(1'b0, 1'b1, 32'h20, 32'h01020304, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    access(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if ({ra, wa, er, rd} !== {3'b101, 32'd0}) begin
      fails++;
      $display("FAIL both got acks %b data %h exp 101 0",
        {ra, wa, er}, rd);
    end
    access(1'b1, 1'b0, 32'h20, 32'h0, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if (rd !== 32'h01020304) begin
      fails++;
      $display("FAIL both_nowrite got %h exp 01020304", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic exp;
    @(negedge clk);
    bus0.dmem_address   = 32'h8;
    bus0.dmem_data_in   = 32'h0BADCAFE;
    bus0.dmem_data_size = MEMOP_WORD;
    bus0.dmem_write_req = 1'b1;
    @(posedge clk);
    #1;
    bus0.dmem_write_req = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (bus0.dmem_write_ack !== 1'b1) begin
      fails++;
      $display("FAIL w0_wack got %b exp 1", bus0.dmem_write_ack);
    end
    @(negedge clk);
    bus0.dmem_read_req = 1'b1;
    #1;
    tests++;
    if (bus0.dmem_busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_busy0 got %b exp 1", bus0.dmem_busy);
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      exp = (k % 2) == 0;
      tests++;
      if ({bus0.dmem_read_ack, bus0.dmem_busy} !== {exp, exp}) begin
        fails++;
        $display("FAIL b2b_cyc%0d got ack %b busy %b exp %b %b", k,
          bus0.dmem_read_ack, bus0.dmem_busy, exp, exp);
      end
      if (exp) begin
        tests++;
        if (bus0.dmem_data_out !== 32'h0BADCAFE) begin
          fails++;
          $display("FAIL b2b_data%0d got %h exp 0badcafe", k,
            bus0.dmem_data_out);
        end
      end
    end
    bus0.dmem_read_req = 1'b0;
  endtask

  task automatic test_reset_abort;
    logic seen;
    access(1'b0, 1'b1, 32'h40, 32'h11111111, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    access(1'b1, 1'b0, 32'h40, 32'h0, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    @(negedge clk);
    bus1.dmem_address   = 32'h40;
    bus1.dmem_data_in   = 32'h99999999;
    bus1.dmem_data_size = MEMOP_WORD;
    bus1.dmem_write_req = 1'b1;
    @(posedge clk);
    #1;
    bus1.dmem_write_req = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (bus1.dmem_data_out !== 32'd0) begin
      fails++;
      $display("FAIL abort_data got %h exp 0", bus1.dmem_data_out);
    end
    tests++;
    if ({bus1.dmem_read_ack, bus1.dmem_write_ack,
         bus1.dmem_busy, bus1.dmem_error} !== 4'b0000) begin
      fails++;
      $display("FAIL abort_flags got %b exp 0000",
        {bus1.dmem_read_ack, bus1.dmem_write_ack,
         bus1.dmem_busy, bus1.dmem_error});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (bus1.dmem_read_ack || bus1.dmem_write_ack) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL abort_noack got %b exp 0", seen);
    end
    access(1'b1, 1'b0, 32'h40, 32'h0, MEMOP_WORD,
      rd, ra, wa, er, lat, bsy);
    tests++;
    if (rd !== 32'h11111111) begin
      fails++;
      $display("FAIL abort_mem got %h exp 11111111", rd);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    bus1.dmem_address   = '0;
    bus1.dmem_data_in   = '0;
    bus1.dmem_data_size = '0;
    bus1.dmem_read_req  = 1'b0;
    bus1.dmem_write_req = 1'b0;
    bus0.dmem_address   = '0;
    bus0.dmem_data_in   = '0;
    bus0.dmem_data_size = '0;
    bus0.dmem_read_req  = 1'b0;
    bus0.dmem_write_req = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_errors();
    test_both();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
